// File: rtl/cva6_accel_dispatch_buffer.sv
// Holds accelerator instructions until commit, then dispatches them in order over a
// valid/ready request channel and forwards responses to writeback one cycle later.
module cva6_accel_dispatch_buffer #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned TRANS_ID_BITS   = 3,
  parameter int unsigned XLEN            = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     issue_valid_i,
  output logic                     issue_ready_o,
  input  logic [31:0]              issue_instr_i,
  input  logic [TRANS_ID_BITS-1:0] issue_trans_id_i,
  input  logic [XLEN-1:0]          issue_rs1_i,
  input  logic [XLEN-1:0]          issue_rs2_i,
  input  logic                     commit_i,
  output logic                     acc_req_valid_o,
  input  logic                     acc_req_ready_i,
  output logic [31:0]              acc_req_instr_o,
  output logic [TRANS_ID_BITS-1:0] acc_req_trans_id_o,
  output logic [XLEN-1:0]          acc_req_rs1_o,
  output logic [XLEN-1:0]          acc_req_rs2_o,
  input  logic                     acc_resp_valid_i,
  input  logic [TRANS_ID_BITS-1:0] acc_resp_trans_id_i,
  input  logic [XLEN-1:0]          acc_resp_result_i,
  input  logic                     acc_resp_error_i,
  output logic                     wb_valid_o,
  output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
  output logic [XLEN-1:0]          wb_result_o,
  output logic                     wb_exception_o,
  output logic                     busy_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

  logic [31:0]              instr_mem [DEPTH];
  logic [TRANS_ID_BITS-1:0] id_mem    [DEPTH];
  logic [XLEN-1:0]          rs1_mem   [DEPTH];
  logic [XLEN-1:0]          rs2_mem   [DEPTH];

  logic [PW-1:0] wr_q, wr_d, commit_q, commit_d, send_q, send_d;
  logic [OW-1:0] outst_q, outst_d;
  logic          busy_q, busy_d;
  logic          full, enq, commit_ok, req_hs, resp_ok;

  logic                     wb_valid_q;
  logic [TRANS_ID_BITS-1:0] wb_trans_id_q;
  logic [XLEN-1:0]          wb_result_q;
  logic                     wb_exception_q;

  assign full          = (wr_q - send_q) == PW'(DEPTH);
  assign issue_ready_o = !full && !flush_i;
  assign enq           = issue_valid_i && issue_ready_o;
  // Commit only counts if a speculative entry was already present this cycle.
  assign commit_ok     = commit_i && (commit_q != wr_q);

  assign acc_req_valid_o    = (send_q != commit_q) && (outst_q < OW'(MAX_OUTSTANDING));
  assign acc_req_instr_o    = instr_mem[send_q[AW-1:0]];
  assign acc_req_trans_id_o = id_mem[send_q[AW-1:0]];
  assign acc_req_rs1_o      = rs1_mem[send_q[AW-1:0]];
  assign acc_req_rs2_o      = rs2_mem[send_q[AW-1:0]];

  assign req_hs  = acc_req_valid_o && acc_req_ready_i;
  // Responses with nothing in flight are stray and dropped.
  assign resp_ok = acc_resp_valid_i && (outst_q != '0);

  always_comb begin
    commit_d = commit_q;
    send_d   = send_q;
    wr_d     = wr_q;
    outst_d  = outst_q;
    if (commit_ok) commit_d = commit_q + PW'(1);
    if (req_hs)    send_d   = send_q + PW'(1);
    if (flush_i) begin
      wr_d = commit_d;
    end else if (enq) begin
      wr_d = wr_q + PW'(1);
    end
    if (req_hs && !resp_ok) begin
      outst_d = outst_q + OW'(1);
    end else if (!req_hs && resp_ok) begin
      outst_d = outst_q - OW'(1);
    end
    busy_d = (wr_d != send_d) || (outst_d != '0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q           <= '0;
      commit_q       <= '0;
      send_q         <= '0;
      outst_q        <= '0;
      busy_q         <= 1'b0;
      wb_valid_q     <= 1'b0;
      wb_trans_id_q  <= '0;
      wb_result_q    <= '0;
      wb_exception_q <= 1'b0;
    end else begin
      wr_q       <= wr_d;
      commit_q   <= commit_d;
      send_q     <= send_d;
      outst_q    <= outst_d;
      busy_q     <= busy_d;
      wb_valid_q <= resp_ok;
      if (resp_ok) begin
        wb_trans_id_q  <= acc_resp_trans_id_i;
        wb_result_q    <= acc_resp_result_i;
        wb_exception_q <= acc_resp_error_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) begin
      instr_mem[wr_q[AW-1:0]] <= issue_instr_i;
      id_mem[wr_q[AW-1:0]]    <= issue_trans_id_i;
      rs1_mem[wr_q[AW-1:0]]   <= issue_rs1_i;
      rs2_mem[wr_q[AW-1:0]]   <= issue_rs2_i;
    end
  end

  assign wb_valid_o     = wb_valid_q;
  assign wb_trans_id_o  = wb_trans_id_q;
  assign wb_result_o    = wb_result_q;
  assign wb_exception_o = wb_exception_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_cva6_accel_dispatch_buffer.sv
// Bench for cva6_accel_dispatch_buffer: directed scenarios plus random traffic, all
// checked every cycle against a queue-based model of the buffer.
module tb_cva6_accel_dispatch_buffer;

  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i, issue_valid_i, issue_ready_o, commit_i;
  logic [31:0] issue_instr_i;
  logic [2:0]  issue_trans_id_i;
  logic [63:0] issue_rs1_i, issue_rs2_i;
  logic        acc_req_valid_o, acc_req_ready_i;
  logic [31:0] acc_req_instr_o;
  logic [2:0]  acc_req_trans_id_o;
  logic [63:0] acc_req_rs1_o, acc_req_rs2_o;
  logic        acc_resp_valid_i, acc_resp_error_i;
  logic [2:0]  acc_resp_trans_id_i;
  logic [63:0] acc_resp_result_i;
  logic        wb_valid_o, wb_exception_o, busy_o;
  logic [2:0]  wb_trans_id_o;
  logic [63:0] wb_result_o;

  cva6_accel_dispatch_buffer dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_instr_i(issue_instr_i), .issue_trans_id_i(issue_trans_id_i),
    .issue_rs1_i(issue_rs1_i), .issue_rs2_i(issue_rs2_i), .commit_i(commit_i),
    .acc_req_valid_o(acc_req_valid_o), .acc_req_ready_i(acc_req_ready_i),
    .acc_req_instr_o(acc_req_instr_o), .acc_req_trans_id_o(acc_req_trans_id_o),
    .acc_req_rs1_o(acc_req_rs1_o), .acc_req_rs2_o(acc_req_rs2_o),
    .acc_resp_valid_i(acc_resp_valid_i), .acc_resp_trans_id_i(acc_resp_trans_id_i),
    .acc_resp_result_i(acc_resp_result_i), .acc_resp_error_i(acc_resp_error_i),
    .wb_valid_o(wb_valid_o), .wb_trans_id_o(wb_trans_id_o), .wb_result_o(wb_result_o),
    .wb_exception_o(wb_exception_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  function automatic void chk(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endfunction

  // Model: q holds all buffered entries oldest first, the first ncom are committed.
  typedef struct {
    logic [31:0] instr;
    logic [2:0]  id;
    logic [63:0] rs1;
    logic [63:0] rs2;
  } ent_t;

  ent_t        q[$];
  int          ncom  = 0;
  int          outst = 0;
  bit          wbv   = 0;
  logic [2:0]  wbid;
  logic [63:0] wbres;
  logic        wbexc;

  initial begin
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        q.delete();
        ncom  = 0;
        outst = 0;
        wbv   = 0;
        chk("rst_req_valid", acc_req_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_wb_valid", wb_valid_o, 0);
      end else begin
        bit exp_rv, hs, rok, enq, cok;
        exp_rv = (ncom > 0) && (outst < MAXO);
        chk("m_issue_ready", issue_ready_o, (q.size() < DEPTH) && !flush_i);
        chk("m_req_valid", acc_req_valid_o, exp_rv);
        if (exp_rv) begin
          chk("m_req_instr", acc_req_instr_o, q[0].instr);
          chk("m_req_id", acc_req_trans_id_o, q[0].id);
          chk("m_req_rs1", acc_req_rs1_o, q[0].rs1);
          chk("m_req_rs2", acc_req_rs2_o, q[0].rs2);
        end
        chk("m_wb_valid", wb_valid_o, wbv);
        if (wbv) begin
          chk("m_wb_id", wb_trans_id_o, wbid);
          chk("m_wb_result", wb_result_o, wbres);
          chk("m_wb_exc", wb_exception_o, wbexc);
        end
        chk("m_busy", busy_o, (q.size() != 0) || (outst != 0));

        hs  = exp_rv && acc_req_ready_i;
        rok = acc_resp_valid_i && (outst != 0);
        enq = issue_valid_i && (q.size() < DEPTH) && !flush_i;
        cok = commit_i && (q.size() > ncom);
        wbv = rok;
        if (rok) begin
          wbid  = acc_resp_trans_id_i;
          wbres = acc_resp_result_i;
          wbexc = acc_resp_error_i;
        end
        outst = outst + int'(hs) - int'(rok);
        if (cok) ncom++;
        if (hs) begin
          void'(q.pop_front());
          ncom--;
        end
        if (flush_i) while (q.size() > ncom) void'(q.pop_back());
        if (enq) q.push_back('{issue_instr_i, issue_trans_id_i, issue_rs1_i, issue_rs2_i});
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_idle();
    flush_i          = 0;
    issue_valid_i    = 0;
    commit_i         = 0;
    acc_req_ready_i  = 0;
    acc_resp_valid_i = 0;
  endtask

  task automatic set_issue(input logic [2:0] id, input logic [63:0] a, input logic [63:0] b);
    issue_valid_i    = 1;
    issue_instr_i    = {24'h0, 5'h0, id};
    issue_trans_id_i = id;
    issue_rs1_i      = a;
    issue_rs2_i      = b;
  endtask

  task automatic set_resp(input logic [2:0] id, input logic [63:0] r, input logic e);
    acc_resp_valid_i    = 1;
    acc_resp_trans_id_i = id;
    acc_resp_result_i   = r;
    acc_resp_error_i    = e;
  endtask

  initial begin
    int hs;
    rst_i = 1;
    drive_idle();
    issue_instr_i = '0; issue_trans_id_i = '0; issue_rs1_i = '0; issue_rs2_i = '0;
    acc_resp_trans_id_i = '0; acc_resp_result_i = '0; acc_resp_error_i = 0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 0;
    #1;
    chk("reset_issue_ready", issue_ready_o, 1);
    chk("reset_req_valid", acc_req_valid_o, 0);
    chk("reset_busy", busy_o, 0);
    chk("reset_wb_valid", wb_valid_o, 0);

    // Uncommitted entry must never be dispatched.
    tick();
    set_issue(3'd1, 64'd5, 64'd7);
    acc_req_ready_i = 1;
    tick();
    issue_valid_i = 0;
    for (int i = 0; i < 10; i++) begin
      #1 chk("t1_spec_hold", acc_req_valid_o, 0);
      tick();
    end
    #1 chk("t1_busy", busy_o, 1);

    // Commit releases it; response comes back on wb one cycle later.
    commit_i = 1;
    #1 chk("t2_valid_pre", acc_req_valid_o, 0);
    tick();
    commit_i = 0;
    #1;
    chk("t2_valid", acc_req_valid_o, 1);
    chk("t2_id", acc_req_trans_id_o, 1);
    chk("t2_rs1", acc_req_rs1_o, 5);
    chk("t2_rs2", acc_req_rs2_o, 7);
    tick();
    acc_req_ready_i = 0;
    set_resp(3'd1, 64'd12, 0);
    #1 chk("t2_wb_early", wb_valid_o, 0);
    tick();
    acc_resp_valid_i = 0;
    #1;
    chk("t2_wb_valid", wb_valid_o, 1);
    chk("t2_wb_result", wb_result_o, 12);
    chk("t2_wb_id", wb_trans_id_o, 1);
    tick();
    #1 chk("t2_wb_pulse", wb_valid_o, 0);
    chk("t2_idle", busy_o, 0);

    // Fill, commit two, flush: two speculative entries vanish.
    for (int i = 0; i < 4; i++) begin
      set_issue(3'(2 + i), 64'(100 + i), 64'(200 + i));
      tick();
    end
    issue_valid_i = 0;
    #1 chk("t3_full", issue_ready_o, 0);
    commit_i = 1;
    tick();
    tick();
    commit_i = 0;
    flush_i = 1;
    set_issue(3'd7, 64'd0, 64'd0);
    #1 chk("t3_flush_ready", issue_ready_o, 0);
    tick();
    flush_i = 0;
    issue_valid_i = 0;
    #1;
    chk("t3_ready_after", issue_ready_o, 1);
    chk("t3_first_id", acc_req_trans_id_o, 2);
    acc_req_ready_i = 1;
    tick();
    #1;
    chk("t3_second_valid", acc_req_valid_o, 1);
    chk("t3_second_id", acc_req_trans_id_o, 3);
    chk("t3_second_rs1", acc_req_rs1_o, 101);
    tick();
    acc_req_ready_i = 0;
    #1 chk("t3_no_third", acc_req_valid_o, 0);
    set_resp(3'd2, 64'd55, 1);
    tick();
    set_resp(3'd3, 64'd66, 0);
    #1;
    chk("t3_wb0_id", wb_trans_id_o, 2);
    chk("t3_wb0_exc", wb_exception_o, 1);
    tick();
    acc_resp_valid_i = 0;
    #1;
    chk("t3_wb1_valid", wb_valid_o, 1);
    chk("t3_wb1_result", wb_result_o, 66);
    tick();
    #1 chk("t3_idle", busy_o, 0);

    // Outstanding limit: only two requests in flight.
    for (int i = 0; i < 3; i++) begin
      set_issue(3'(i), 64'(i), 64'(i));
      tick();
    end
    issue_valid_i = 0;
    commit_i = 1;
    repeat (3) tick();
    commit_i = 0;
    acc_req_ready_i = 1;
    hs = 0;
    repeat (6) begin
      #1 if (acc_req_valid_o) hs++;
      tick();
    end
    chk("t4_handshakes", 64'(hs), 2);
    #1 chk("t4_capped", acc_req_valid_o, 0);
    set_resp(3'd0, 64'd1, 0);
    #1 chk("t4_resp_cycle", acc_req_valid_o, 0);
    tick();
    acc_resp_valid_i = 0;
    #1;
    chk("t4_third_valid", acc_req_valid_o, 1);
    chk("t4_third_id", acc_req_trans_id_o, 2);
    tick();
    acc_req_ready_i = 0;
    set_resp(3'd1, 64'd2, 0);
    tick();
    tick();
    acc_resp_valid_i = 0;
    tick();
    #1 chk("t4_idle", busy_o, 0);

    // Stray response and useless commits.
    set_resp(3'd5, 64'd9, 0);
    tick();
    acc_resp_valid_i = 0;
    #1;
    chk("t5_stray_wb", wb_valid_o, 0);
    chk("t5_stray_busy", busy_o, 0);
    commit_i = 1;
    tick();
    set_issue(3'd6, 64'd60, 64'd61);
    tick();
    commit_i = 0;
    issue_valid_i = 0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("t5_not_committed", acc_req_valid_o, 0);
      tick();
    end
    commit_i = 1;
    tick();
    commit_i = 0;
    acc_req_ready_i = 1;
    #1;
    chk("t5_valid", acc_req_valid_o, 1);
    chk("t5_id", acc_req_trans_id_o, 6);
    tick();
    acc_req_ready_i = 0;
    set_resp(3'd6, 64'd3, 0);
    tick();
    acc_resp_valid_i = 0;
    tick();

    // Reset in the middle of traffic.
    for (int i = 0; i < 3; i++) begin
      set_issue(3'(i + 1), 64'(i), 64'(i));
      tick();
    end
    issue_valid_i = 0;
    commit_i = 1;
    repeat (3) tick();
    commit_i = 0;
    acc_req_ready_i = 1;
    tick();
    tick();
    acc_req_ready_i = 0;
    #1;
    chk("t6_capped", acc_req_valid_o, 0);
    chk("t6_busy", busy_o, 1);
    rst_i = 1;
    #1;
    chk("t6_rst_valid", acc_req_valid_o, 0);
    chk("t6_rst_busy", busy_o, 0);
    tick();
    tick();
    rst_i = 0;
    #1 chk("t6_ready", issue_ready_o, 1);
    set_resp(3'd1, 64'd77, 0);
    tick();
    acc_resp_valid_i = 0;
    #1;
    chk("t6_late_wb", wb_valid_o, 0);
    chk("t6_late_busy", busy_o, 0);
    chk("t6_late_req", acc_req_valid_o, 0);

    // Random traffic.
    repeat (4000) begin
      rst_i               = ($urandom_range(0, 399) == 0);
      flush_i             = ($urandom_range(0, 19) == 0);
      issue_valid_i       = $urandom_range(0, 1);
      issue_instr_i       = $urandom;
      issue_trans_id_i    = 3'($urandom);
      issue_rs1_i         = {$urandom, $urandom};
      issue_rs2_i         = {$urandom, $urandom};
      commit_i            = ($urandom_range(0, 9) < 4);
      acc_req_ready_i     = $urandom_range(0, 1);
      acc_resp_valid_i    = ($urandom_range(0, 9) < 3);
      acc_resp_trans_id_i = 3'($urandom);
      acc_resp_result_i   = {$urandom, $urandom};
      acc_resp_error_i    = $urandom_range(0, 1);
      tick();
    end
    rst_i = 0;
    drive_idle();
    tick();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
